// File: rtl/video_sync_chain.sv
// Horizontal/vertical raster timing built as a cascaded 4-bit counter chain.
// Every output is registered or decoded from registered counts, so the downstream AND gates see clean levels.
module video_sync_chain #(
  parameter int H_TOTAL      = 384,
  parameter int H_VISIBLE    = 256,
  parameter int H_SYNC_START = 296,
  parameter int H_SYNC_WIDTH = 32,
  parameter int V_TOTAL      = 264,
  parameter int V_VISIBLE    = 240,
  parameter int V_SYNC_START = 248,
  parameter int V_SYNC_WIDTH = 4
) (
  input  logic       CLK,
  input  logic       _CLR,
  input  logic       CE,
  output logic [8:0] H,
  output logic [8:0] V,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       _HSYNC,
  output logic       _VSYNC,
  output logic       LINE_END,
  output logic       FRAME_END
);

  generate
    if (H_TOTAL < 2 || H_TOTAL > 512 || V_TOTAL < 2 || V_TOTAL > 512 ||
        H_VISIBLE > H_TOTAL || V_VISIBLE > V_TOTAL ||
        H_SYNC_WIDTH < 1 || V_SYNC_WIDTH < 1) begin : g_bad_params
      $error("video_sync_chain: illegal timing parameter set");
    end
  endgenerate

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO  = 10'(H_SYNC_START);
  localparam logic [9:0] HS_HI  = 10'(H_SYNC_START + H_SYNC_WIDTH);
  localparam logic [9:0] VS_LO  = 10'(V_SYNC_START);
  localparam logic [9:0] VS_HI  = 10'(V_SYNC_START + V_SYNC_WIDTH);

  // Increment through two 4-bit stages and a 1-bit top stage, carry rippling upward.
  function automatic logic [8:0] chain_inc(input logic [8:0] cnt);
    logic [4:0] s0;
    logic [4:0] s1;
    logic       s2;
    s0 = {1'b0, cnt[3:0]} + 5'd1;
    s1 = {1'b0, cnt[7:4]} + {4'd0, s0[4]};
    s2 = cnt[8] ^ s1[4];
    return {s2, s1[3:0], s0[3:0]};
  endfunction

  // Windows are not wrapped: counts never exceed TOTAL-1, so an overlong window truncates naturally.
  function automatic logic in_window(input logic [8:0] cnt, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return ({1'b0, cnt} >= lo) && ({1'b0, cnt} < hi);
  endfunction

  logic [8:0] h_p0;
  logic [8:0] v_p0;
  logic       hblank_p0;
  logic       vblank_p0;
  logic       hsync_n_p0;
  logic       vsync_n_p0;

  logic [8:0] h_inc;
  logic [8:0] v_inc;
  logic       line_wrap;
  logic [8:0] h_nxt;
  logic [8:0] v_nxt;

  always_comb begin
    h_inc     = chain_inc(h_p0);
    v_inc     = chain_inc(v_p0);
    line_wrap = (h_p0 == H_LAST);
    h_nxt     = line_wrap ? 9'd0 : h_inc;
    v_nxt     = v_p0;
    if (line_wrap) begin
      v_nxt = (v_p0 == V_LAST) ? 9'd0 : v_inc;
    end
  end

  // Stage p0: counts and the strobes decoded from their next-state values
  always_ff @(posedge CLK or negedge _CLR) begin
    if (!_CLR) begin
      h_p0       <= 9'd0;
      v_p0       <= 9'd0;
      hblank_p0  <= 1'b0;
      vblank_p0  <= 1'b0;
      hsync_n_p0 <= 1'b1;
      vsync_n_p0 <= 1'b1;
    end else if (CE) begin
      h_p0       <= h_nxt;
      v_p0       <= v_nxt;
      hblank_p0  <= ({1'b0, h_nxt} >= H_VIS);
      vblank_p0  <= ({1'b0, v_nxt} >= V_VIS);
      hsync_n_p0 <= !in_window(h_nxt, HS_LO, HS_HI);
      vsync_n_p0 <= !in_window(v_nxt, VS_LO, VS_HI);
    end
  end

  assign H         = h_p0;
  assign V         = v_p0;
  assign HBLANK    = hblank_p0;
  assign VBLANK    = vblank_p0;
  assign _HSYNC    = hsync_n_p0;
  assign _VSYNC    = vsync_n_p0;
  assign LINE_END  = (h_p0 == H_LAST);
  assign FRAME_END = (h_p0 == H_LAST) && (v_p0 == V_LAST);

endmodule

// File: tb/tb_video_sync_chain.sv
// Directed bench for video_sync_chain: default horizontal timing, shortened frame
// (20 lines, sync window 17..20 running past the last line) to keep the frame scan short.
module tb_video_sync_chain;

  localparam int TB_H_TOTAL = 384;
  localparam int TB_V_TOTAL = 20;

  logic       CLK;
  logic       clr_n;
  logic       ce;
  logic [8:0] H;
  logic [8:0] V;
  logic       HBLANK;
  logic       VBLANK;
  logic       hsync_n;
  logic       vsync_n;
  logic       LINE_END;
  logic       FRAME_END;

  int vectors;
  int miscompares;

  video_sync_chain #(
    .H_TOTAL(384), .H_VISIBLE(256), .H_SYNC_START(296), .H_SYNC_WIDTH(32),
    .V_TOTAL(20), .V_VISIBLE(16), .V_SYNC_START(17), .V_SYNC_WIDTH(4)
  ) dut (
    .CLK(CLK), ._CLR(clr_n), .CE(ce),
    .H(H), .V(V), .HBLANK(HBLANK), .VBLANK(VBLANK),
    ._HSYNC(hsync_n), ._VSYNC(vsync_n),
    .LINE_END(LINE_END), .FRAME_END(FRAME_END)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  int mh, mv;
  int pos_err, vs_low, vb_high, hb_high, comp_low, run, glitches, fe_cnt, fe_h, fe_v;

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr_n = 1'b0;
    ce    = 1'b1;
    #2;

    for (int i = 0; i < 5; i++) begin
      step(1);
      check("rst_h", H, 0);
      check("rst_v", V, 0);
      check("rst_hsync", hsync_n, 1);
      check("rst_vsync", vsync_n, 1);
      check("rst_hblank", HBLANK, 0);
      check("rst_vblank", VBLANK, 0);
      check("rst_line_end", LINE_END, 0);
      check("rst_frame_end", FRAME_END, 0);
    end

    clr_n = 1'b1;
    step(1);
    check("first_edge_h", H, 1);
    step(99);
    check("h100", H, 100);

    // Clear between edges: must act before the next edge.
    #3 clr_n = 1'b0;
    #1 check("async_clr_h", H, 0);
    step(1);
    check("clr_held_h", H, 0);
    clr_n = 1'b1;

    step(255);
    check("h255", H, 255);
    check("hblank_h255", HBLANK, 0);
    step(1);
    check("hblank_h256", HBLANK, 1);
    step(39);
    check("hsync_h295", hsync_n, 1);
    step(1);
    check("hsync_h296", hsync_n, 0);
    step(31);
    check("hsync_h327", hsync_n, 0);
    step(1);
    check("hsync_h328", hsync_n, 1);
    step(55);
    check("h383", H, 383);
    check("line_end_h383", LINE_END, 1);
    check("frame_end_v0", FRAME_END, 0);
    check("v_before_wrap", V, 0);

    ce = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("stall_h", H, 383);
      check("stall_v", V, 0);
      check("stall_line_end", LINE_END, 1);
      check("stall_hblank", HBLANK, 1);
    end
    ce = 1'b1;
    step(1);
    check("wrap_h", H, 0);
    check("wrap_v", V, 1);
    check("wrap_hblank", HBLANK, 0);
    check("wrap_line_end", LINE_END, 0);

    step(300);
    check("midsync_h", H, 300);
    check("midsync_hsync", hsync_n, 0);
    #3 clr_n = 1'b0;
    #1 check("midsync_clr_hsync", hsync_n, 1);
    check("midsync_clr_v", V, 0);
    step(1);
    clr_n = 1'b1;

    // Full frame scan from H=0,V=0.
    mh = 0; mv = 0;
    pos_err = 0; vs_low = 0; vb_high = 0; hb_high = 0;
    comp_low = 0; run = 0; glitches = 0; fe_cnt = 0; fe_h = -1; fe_v = -1;
    for (int e = 0; e < TB_H_TOTAL * TB_V_TOTAL; e++) begin
      if (mh == TB_H_TOTAL - 1) begin
        mh = 0;
        mv = (mv == TB_V_TOTAL - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      step(1);
      if (H !== 9'(mh) || V !== 9'(mv)) pos_err++;
      if (vsync_n === 1'b0) vs_low++;
      if (VBLANK === 1'b1) vb_high++;
      if (HBLANK === 1'b1) hb_high++;
      if (FRAME_END === 1'b1) begin
        fe_cnt++;
        fe_h = int'(H);
        fe_v = int'(V);
      end
      if ((hsync_n & vsync_n) === 1'b0) begin
        comp_low++;
        run++;
      end else begin
        if (run == 1) glitches++;
        run = 0;
      end
    end
    check("frame_pos_errors", pos_err, 0);
    check("frame_vsync_low", vs_low, 3 * 384);
    check("frame_vblank_high", vb_high, 4 * 384);
    check("frame_hblank_high", hb_high, 128 * 20);
    check("frame_end_count", fe_cnt, 1);
    check("frame_end_h", fe_h, 383);
    check("frame_end_v", fe_v, 19);
    check("composite_low", comp_low, 1696);
    check("composite_glitches", glitches, 0);
    check("after_frame_h", H, 0);
    check("after_frame_v", V, 0);
    check("after_frame_vsync", vsync_n, 1);
    check("after_frame_vblank", VBLANK, 0);
    check("after_frame_frame_end", FRAME_END, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
